// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Purpose:
//   Shares the single register-file write port (and the ps flag write)
//   between two requesters:
//     A : ALU/jump writeback stream. It is back-pressured through a_ready.
//     M : load data returning from a multi-cycle memory. It is buffered in
//         a small FIFO and accepted whenever m_ready is high.
//   Writes to the same destination register leave in program order. A
//   buffered load is never overtaken by a later A write to the same
//   register. A wait counter keeps the FIFO head from being starved by a
//   continuous A stream.
//
// Handshakes:
//   A transfer happens in a cycle where a_valid && a_ready. a_ready is
//   combinational and means "A is granted the write port this cycle".
//   An M transfer happens in a cycle where m_valid && m_ready. m_ready is
//   combinational and is high whenever the FIFO has a free slot.
//   Neither ready waits on its own valid, so the upstream side may hold
//   valid and sample ready in the same cycle.
//
// Ports:
//   clk, n_rst        clock (rising edge), asynchronous active-low reset
//   a_valid           A request valid
//   a_use_rw          A writes a register
//   a_rw_addr         A destination register
//   a_data            A write data
//   a_write_ps        A writes the ps flag
//   a_ps              A ps value
//   a_ready           A granted this cycle (combinational)
//   m_valid           memory return valid
//   m_rw_addr         load destination register
//   m_data            load data
//   m_ready           FIFO can accept (combinational)
//   wr_en/wr_addr/wr_data  registered register-file write port
//   ps_en/ps_out      registered ps flag write
//   fifo_count        number of buffered loads
// ---------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       a_valid,
    input  logic                       a_use_rw,
    input  logic [3:0]                 a_rw_addr,
    input  logic [15:0]                a_data,
    input  logic                       a_write_ps,
    input  logic                       a_ps,
    output logic                       a_ready,
    input  logic                       m_valid,
    input  logic [3:0]                 m_rw_addr,
    input  logic [15:0]                m_data,
    output logic                       m_ready,
    output logic                       wr_en,
    output logic [3:0]                 wr_addr,
    output logic [15:0]                wr_data,
    output logic                       ps_en,
    output logic                       ps_out,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    // FIFO storage. There is no reset on the storage itself; only the
    // pointers and the count define which entries are live.
    logic [3:0]    addr_mem [DEPTH];
    logic [15:0]   data_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [WW-1:0] wait_q,   wait_d;

    logic          wr_en_q,   wr_en_d;
    logic [3:0]    wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          ps_en_q,   ps_en_d;
    logic          ps_out_q,  ps_out_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          stored_hit;
    logic          hazard;
    logic          a_elig;
    logic          grant_a;
    logic [PW-1:0] scan_idx;

    // -----------------------------------------------------------------------
    // FIFO status and push
    // -----------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign m_ready    = !fifo_full;
    // While full m_ready is low, so no push can happen even if the head
    // pops in the same cycle.
    assign push       = m_valid && m_ready;

    // -----------------------------------------------------------------------
    // Ordering hazard: an A write may not overtake a buffered load (or the
    // load arriving this cycle) that targets the same register. Only the
    // `count_q` entries starting at the head are live.
    // -----------------------------------------------------------------------
    always_comb begin
        stored_hit = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_mem[scan_idx] == a_rw_addr)) begin
                stored_hit = 1'b1;
            end
        end
    end

    assign hazard = a_valid && a_use_rw &&
                    (stored_hit || (push && (m_rw_addr == a_rw_addr)));
    assign a_elig = a_valid && !hazard;

    // -----------------------------------------------------------------------
    // Grant: at most one winner per cycle. The head is forced through when
    // it has waited long enough or the FIFO is full. An entry pushed this
    // cycle is not yet visible at the head, because pop only looks at
    // count_q.
    // -----------------------------------------------------------------------
    assign pop     = !fifo_empty &&
                     (!a_elig || (wait_q >= WW'(MAX_WAIT)) || fifo_full);
    assign grant_a = a_elig && !pop;
    assign a_ready = grant_a;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // The wait counter measures how many cycles the current head has lost
    // the arbitration. It saturates at MAX_WAIT.
    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q < WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end
    end

    // Write port is registered: the winner of cycle N appears at N+1.
    // Address, data and ps value hold when there is no grant; the enables
    // drop.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ps_en_d   = 1'b0;
        ps_out_d  = ps_out_q;
        if (grant_a) begin
            wr_en_d   = a_use_rw;
            wr_addr_d = a_rw_addr;
            wr_data_d = a_data;
            ps_en_d   = a_write_ps;
            ps_out_d  = a_ps;
        end else if (pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_mem[rd_ptr_q];
            wr_data_d = data_mem[rd_ptr_q];
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ps_en_q   <= 1'b0;
            ps_out_q  <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ps_en_q   <= ps_en_d;
            ps_out_q  <= ps_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= m_rw_addr;
            data_mem[wr_ptr_q] <= m_data;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign ps_en      = ps_en_q;
    assign ps_out     = ps_out_q;
    assign fifo_count = count_q;

    // -----------------------------------------------------------------------
    // Structural properties
    // -----------------------------------------------------------------------
    a_one_winner : assert property (@(posedge clk) disable iff (!n_rst)
        !(grant_a && pop));
    a_count_bound : assert property (@(posedge clk) disable iff (!n_rst)
        count_q <= CW'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (!n_rst)
        fifo_full |-> !push);
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!n_rst)
        fifo_empty |-> !pop);

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed bench for writeback_arbiter (DEPTH=4, MAX_WAIT=3). Inputs change
// 1 ns after the rising edge. Combinational readies are sampled 1 ns after
// that. Registered outputs are sampled 1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

    logic        clk;
    logic        n_rst;
    logic        a_valid;
    logic        a_use_rw;
    logic [3:0]  a_rw_addr;
    logic [15:0] a_data;
    logic        a_write_ps;
    logic        a_ps;
    logic        a_ready;
    logic        m_valid;
    logic [3:0]  m_rw_addr;
    logic [15:0] m_data;
    logic        m_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        ps_en;
    logic        ps_out;
    logic [2:0]  fifo_count;

    int n_tests;
    int n_fail;

    logic [31:0] exp_q[$];

    writeback_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .a_valid    (a_valid),
        .a_use_rw   (a_use_rw),
        .a_rw_addr  (a_rw_addr),
        .a_data     (a_data),
        .a_write_ps (a_write_ps),
        .a_ps       (a_ps),
        .a_ready    (a_ready),
        .m_valid    (m_valid),
        .m_rw_addr  (m_rw_addr),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ps_en      (ps_en),
        .ps_out     (ps_out),
        .fifo_count (fifo_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Checking and driver tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid    = 1'b0;
        a_use_rw   = 1'b0;
        a_rw_addr  = 4'h0;
        a_data     = 16'h0;
        a_write_ps = 1'b0;
        a_ps       = 1'b0;
        m_valid    = 1'b0;
        m_rw_addr  = 4'h0;
        m_data     = 16'h0;
    endtask

    task automatic drive_a(input logic [3:0] addr, input logic [15:0] data,
                           input logic use_rw, input logic wps, input logic ps);
        a_valid    = 1'b1;
        a_use_rw   = use_rw;
        a_rw_addr  = addr;
        a_data     = data;
        a_write_ps = wps;
        a_ps       = ps;
    endtask

    task automatic drive_m(input logic [3:0] addr, input logic [15:0] data);
        m_valid   = 1'b1;
        m_rw_addr = addr;
        m_data    = data;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        n_rst = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_ps_en", ps_en, 0);
        check("rst_ps_out", ps_out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_m_ready", m_ready, 1);
        n_rst = 1'b1;
        tick();

        // ---------------- A only ----------------
        drive_a(4'd5, 16'h1234, 1'b1, 1'b1, 1'b1);
        #1 check("aonly_a_ready", a_ready, 1);
        tick();
        idle_inputs();
        check("aonly_wr_en", wr_en, 1);
        check("aonly_wr_addr", wr_addr, 5);
        check("aonly_wr_data", wr_data, 16'h1234);
        check("aonly_ps_en", ps_en, 1);
        check("aonly_ps_out", ps_out, 1);
        tick();
        check("idle_wr_en", wr_en, 0);
        check("idle_ps_en", ps_en, 0);
        check("idle_addr_hold", wr_addr, 5);
        check("idle_data_hold", wr_data, 16'h1234);
        check("idle_ps_hold", ps_out, 1);

        // ---------------- A with no write ----------------
        drive_a(4'd6, 16'h6666, 1'b0, 1'b0, 1'b0);
        #1 check("nowr_a_ready", a_ready, 1);
        tick();
        idle_inputs();
        check("nowr_wr_en", wr_en, 0);
        check("nowr_ps_en", ps_en, 0);

        // ---------------- starvation guard ----------------
        drive_a(4'd7, 16'h0700, 1'b1, 1'b0, 1'b0);
        drive_m(4'd3, 16'hBEEF);
        #1;
        check("starve_a_ready0", a_ready, 1);
        check("starve_m_ready", m_ready, 1);
        tick();
        m_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("starve_prev_addr", wr_addr, 7);
            check("starve_prev_data", wr_data, 32'h0700 + c - 1);
            a_data = 16'h0700 + 16'(c);
            #1;
            check("starve_a_ready", a_ready, (c < 4) ? 1 : 0);
            check("starve_count", fifo_count, 1);
            tick();
        end
        a_valid = 1'b0;
        check("starve_pop_en", wr_en, 1);
        check("starve_pop_addr", wr_addr, 3);
        check("starve_pop_data", wr_data, 16'hBEEF);
        check("starve_pop_ps_en", ps_en, 0);
        check("starve_count_end", fifo_count, 0);
        tick();
        check("starve_idle", wr_en, 0);

        // ---------------- hazard against stored entry ----------------
        drive_m(4'd4, 16'h4444);
        tick();
        m_valid = 1'b0;
        drive_a(4'd4, 16'hA4A4, 1'b1, 1'b1, 1'b0);
        #1 check("haz_a_blocked", a_ready, 0);
        tick();
        check("haz_load_en", wr_en, 1);
        check("haz_load_addr", wr_addr, 4);
        check("haz_load_data", wr_data, 16'h4444);
        #1 check("haz_a_after", a_ready, 1);
        tick();
        check("haz_a_data", wr_data, 16'hA4A4);
        check("haz_a_ps_en", ps_en, 1);

        // ---------------- hazard against same-cycle push ----------------
        drive_a(4'd9, 16'hA9A9, 1'b1, 1'b0, 1'b0);
        drive_m(4'd9, 16'h9999);
        #1 check("hazp_a_blocked", a_ready, 0);
        tick();
        m_valid = 1'b0;
        check("hazp_no_grant", wr_en, 0);
        #1 check("hazp_a_blocked2", a_ready, 0);
        tick();
        check("hazp_load_data", wr_data, 16'h9999);
        #1 check("hazp_a_after", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check("hazp_a_data", wr_data, 16'hA9A9);

        // ---------------- fill to full ----------------
        for (int c = 0; c < 4; c++) begin
            drive_a(4'hA, 16'hAA00 + 16'(c), 1'b1, 1'b0, 1'b0);
            drive_m(4'(c + 1), 16'h1000 + 16'(c + 1));
            #1;
            check("fill_m_ready", m_ready, 1);
            check("fill_a_ready", a_ready, 1);
            check("fill_count", fifo_count, c);
            tick();
        end
        drive_m(4'd5, 16'h1005);
        #1;
        check("full_m_ready", m_ready, 0);
        check("full_a_ready", a_ready, 0);
        check("full_count", fifo_count, 4);
        tick();
        check("full_pop_addr", wr_addr, 1);
        check("full_pop_data", wr_data, 16'h1001);
        #1;
        check("refill_m_ready", m_ready, 1);
        check("refill_a_ready", a_ready, 1);
        check("refill_count", fifo_count, 3);
        tick();
        idle_inputs();
        check("refill_a_addr", wr_addr, 4'hA);
        for (int k = 2; k <= 5; k++) begin
            #1 check("drain_count", fifo_count, 6 - k);
            tick();
            check("drain_en", wr_en, 1);
            check("drain_addr", wr_addr, k);
            check("drain_data", wr_data, 32'h1000 + k);
        end
        check("drain_empty", fifo_count, 0);

        // ---------------- wrap: push/pop pairs ----------------
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                drive_m(4'(i), 16'h5000 + 16'(i));
                exp_q.push_back(32'h5000 + i);
            end else begin
                m_valid = 1'b0;
            end
            #1 check("wrap_count", fifo_count, (i == 0) ? 0 : 1);
            tick();
            if (i == 0) begin
                check("wrap_first_no_pop", wr_en, 0);
            end else begin
                check("wrap_en", wr_en, 1);
                check("wrap_data", wr_data, exp_q.pop_front());
            end
        end
        check("wrap_empty", fifo_count, 0);

        // ---------------- asynchronous reset mid-operation ----------------
        drive_a(4'hF, 16'hF000, 1'b1, 1'b1, 1'b1);
        drive_m(4'd2, 16'h2222);
        tick();
        a_data = 16'hF001;
        m_rw_addr = 4'd3;
        m_data = 16'h3333;
        tick();
        idle_inputs();
        check("pre_rst_count", fifo_count, 2);
        check("pre_rst_wr_en", wr_en, 1);
        #3 n_rst = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_ps_en", ps_en, 0);
        check("arst_ps_out", ps_out, 0);
        check("arst_count", fifo_count, 0);
        #1 n_rst = 1'b1;
        tick();
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_count", fifo_count, 0);
        tick();
        check("post_rst_wr_en2", wr_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single register-file write port (plus the ps flag write) between two requesters.
- Requester A: the ALU/jump writeback stream (writeback_glue_circuit output fields).
- Requester M: load data returning from a multi-cycle memory.
- M is buffered in a small FIFO. A is back-pressured via a_ready. Program order to the same destination register is preserved, and M is protected from starvation by a wait counter.

Parameters:
- DEPTH, 4, memory-return FIFO entries (power of two, ≥2).
- MAX_WAIT, 3, cycles the FIFO head may lose arbitration before it is forced through.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- a_valid  input  1  A request valid.
- a_use_rw  input  1  A writes a register.
- a_rw_addr  input  4  A destination register.
- a_data  input  16  A write data.
- a_write_ps  input  1  A writes the ps flag.
- a_ps  input  1  A ps value.
- a_ready  output  1  A granted this cycle (combinational).
- m_valid  input  1  memory return valid.
- m_rw_addr  input  4  load destination register.
- m_data  input  16  load data.
- m_ready  output  1  FIFO can accept (combinational, = count < DEPTH).
- wr_en  output  1  regfile write enable (registered).
- wr_addr  output  4  regfile write address (registered).
- wr_data  output  16  regfile write data (registered).
- ps_en  output  1  ps write enable (registered).
- ps_out  output  1  ps value (registered).
- fifo_count  output  $clog2(DEPTH+1)  stored entries.

Behaviour:
- Reset (async, n_rst=0): FIFO emptied (pointers and count = 0), wait_cnt = 0. wr_en, wr_addr, wr_data, ps_en, ps_out all 0. Reset mid-operation discards every buffered load.
- M push: occurs when m_valid && m_ready. The entry is stored at the tail. A pushed entry is never popped in the same cycle, so minimum FIFO latency is 1 cycle to grant.
- Hazard: asserted when a_valid && a_use_rw and a_rw_addr equals the addr of any stored valid entry or of the entry pushed this cycle. A hazarded A is not eligible.
- Eligibility: A_elig = a_valid && !hazard.
- Grant, one per cycle:
  - FIFO empty: grant A if A_elig.
  - FIFO non-empty: grant the head (pop) if !A_elig, or wait_cnt ≥ MAX_WAIT, or count == DEPTH. Otherwise grant A.
- Outputs: a_ready = A granted.
- A with a_use_rw=0 and a_write_ps=0 is still granted and consumed, and produces no write.
- Wait counter:
  - wait_cnt increments when the FIFO is non-empty and the head is not popped (saturates at MAX_WAIT).
  - Clears on pop or when the FIFO is empty.
- Output register, updated on the next edge after grant (latency 1):
  - A granted: wr_en = a_use_rw, wr_addr/wr_data = a_rw_addr/a_data, ps_en = a_write_ps, ps_out = a_ps.
  - Pop: wr_en = 1, wr_addr/wr_data = head fields, ps_en = 0, ps_out holds.
  - No grant: wr_en = 0, ps_en = 0, addr/data hold.
- Count arithmetic: count' = count + push − pop. Simultaneous push and pop with count < DEPTH leaves count unchanged. Pointers wrap modulo DEPTH.
- Full FIFO: m_ready = 0 and the head is forced. No push occurs while full, even if a pop happens the same cycle.
- Invariants:
  - wr_en is never asserted for both sources in one cycle.
  - Writes to the same register leave in program order (load before a later A to that register).

Test Plan:
- Reset with FIFO holding 2 entries, n_rst pulsed low mid-cycle → outputs 0 immediately. fifo_count = 0 after release, and no stale write occurs.
- A only: a_valid=1, addr 5, data 0x1234, write_ps=1, ps=1 → a_ready=1 same cycle. Next cycle wr_en=1, wr_addr=5, wr_data=0x1234, ps_en=1, ps_out=1.
- M push (addr 3, 0xBEEF) while A streams to addr 7 every cycle → A granted for 3 cycles, then head forced on the 4th (wait_cnt=3). wr_en with addr 3/0xBEEF appears one cycle later, and a_ready=0 that cycle.
- Hazard: stored entry to addr 4, A targets addr 4 → a_ready=0 and the head pops. The load write to addr 4 precedes the A write to addr 4 by ≥1 cycle.
- Fill: 4 pushes with A continuously valid to non-conflicting addrs → m_ready=0 at count=4, and the head pops immediately. The 5th m_valid is held until m_ready returns.
- Wrap: 10 push/pop pairs with distinct data → output order matches input order, and fifo_count never exceeds DEPTH.
